// File: rtl/voice_allocator_if.sv
// voice_allocator_if: key switch inputs and voice control outputs of the polyphony allocator
interface voice_allocator_if #(
    parameter int NUM_KEYS   = 15,
    parameter int NUM_VOICES = 4
);
    logic                      ENABLE;
    logic [NUM_KEYS-1:0]       Switch;
    logic [NUM_VOICES-1:0]     VOICE_GATE;
    logic [4*NUM_VOICES-1:0]   VOICE_NOTE;
    logic [NUM_VOICES-1:0]     VOICE_START;
    logic                      VOICE_FULL;
    modport master (output ENABLE, Switch, input VOICE_GATE, VOICE_NOTE, VOICE_START, VOICE_FULL);
    modport slave  (input ENABLE, Switch, output VOICE_GATE, VOICE_NOTE, VOICE_START, VOICE_FULL);
endinterface

// File: rtl/voice_allocator.sv
// voice_allocator: scans keys one per clock, assigns pressed keys to free voices, steals the oldest when full
module voice_allocator #(
    parameter int NUM_KEYS   = 15,
    parameter int NUM_VOICES = 4
) (
    input logic             CLK,
    input logic             RESET_N,
    voice_allocator_if.slave bus
);
    localparam int VW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
    typedef enum logic [1:0] {IDLE, ACTIVE, STOLEN} key_t;
    logic [NUM_KEYS-1:0]   sw_meta, sw;
    logic [3:0]            idx, idx_n;
    key_t                  kst [NUM_KEYS];
    key_t                  kst_n [NUM_KEYS];
    logic [VW-1:0]         kv [NUM_KEYS];
    logic [VW-1:0]         kv_n [NUM_KEYS];
    logic [3:0]            age [NUM_VOICES];
    logic [3:0]            age_n [NUM_VOICES];
    logic [3:0]            note [NUM_VOICES];
    logic [3:0]            note_n [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate, gate_n, start, start_n;
    logic [VW-1:0]         free_v, old_v, alloc_v;
    logic                  free_found;
    logic [3:0]            old_age;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sw_meta <= '0;
            sw      <= '0;
            idx     <= '0;
            gate    <= '0;
            start   <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                kst[k] <= IDLE;
                kv[k]  <= '0;
            end
            for (int v = 0; v < NUM_VOICES; v++) begin
                age[v]  <= '0;
                note[v] <= '0;
            end
        end else begin
            sw_meta <= bus.Switch;
            sw      <= sw_meta;
            idx     <= idx_n;
            kst     <= kst_n;
            kv      <= kv_n;
            age     <= age_n;
            note    <= note_n;
            gate    <= gate_n;
            start   <= start_n;
        end
    end

    always_comb begin
        free_found = 1'b0;
        free_v     = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--)
            if (!gate[v]) begin
                free_found = 1'b1;
                free_v     = VW'(v);
            end
        // strict greater-than keeps the lowest index on equal ages
        old_v   = '0;
        old_age = age[0];
        for (int v = 1; v < NUM_VOICES; v++)
            if (age[v] > old_age) begin
                old_v   = VW'(v);
                old_age = age[v];
            end
        alloc_v = free_found ? free_v : old_v;
        idx_n   = idx;
        kst_n   = kst;
        kv_n    = kv;
        age_n   = age;
        note_n  = note;
        gate_n  = gate;
        start_n = '0;
        if (!bus.ENABLE) begin
            idx_n  = '0;
            gate_n = '0;
            for (int k = 0; k < NUM_KEYS; k++) kst_n[k] = IDLE;
            for (int v = 0; v < NUM_VOICES; v++) age_n[v] = '0;
        end else begin
            idx_n = (idx == 4'(NUM_KEYS - 1)) ? '0 : idx + 4'd1;
            if (kst[idx] == IDLE && sw[idx]) begin
                for (int v = 0; v < NUM_VOICES; v++)
                    age_n[v] = (VW'(v) == alloc_v) ? '0 :
                               (gate[v] && age[v] != 4'hf) ? age[v] + 4'd1 : age[v];
                if (gate[alloc_v]) kst_n[note[alloc_v]] = STOLEN;
                kst_n[idx]       = ACTIVE;
                kv_n[idx]        = alloc_v;
                gate_n[alloc_v]  = 1'b1;
                note_n[alloc_v]  = idx;
                start_n[alloc_v] = 1'b1;
            end else if (kst[idx] == ACTIVE && !sw[idx]) begin
                gate_n[kv[idx]] = 1'b0;
                age_n[kv[idx]]  = '0;
                kst_n[idx]      = IDLE;
            end else if (kst[idx] == STOLEN && !sw[idx]) begin
                kst_n[idx] = IDLE;
            end
        end
    end

    always_comb begin
        bus.VOICE_GATE  = gate;
        bus.VOICE_START = start;
        bus.VOICE_FULL  = &gate;
        bus.VOICE_NOTE  = '0;
        for (int v = 0; v < NUM_VOICES; v++) bus.VOICE_NOTE[4*v+:4] = note[v];
    end
endmodule
